// File: rtl/tester_common_pkg.sv
// Shared definitions for the traffic tester blocks.
//   port_config_t  : per-test configuration handed to a port generator
//   fg_state_t     : frame generator control states
//   frame_byte()   : content of one byte of a generated test frame
package tester_common;

  localparam logic [15:0] ETHERTYPE     = 16'h88B5;
  localparam logic [15:0] MIN_FRAME_LEN = 16'd60;
  localparam logic [15:0] MAX_FRAME_LEN = 16'd1514;
  // Width of the gap field carried in the config struct; a generator with a
  // narrower gap counter keeps only the low bits.
  localparam int          CFG_GAP_WIDTH = 16;

  typedef struct packed {
    logic [47:0]              dst_mac;
    logic [47:0]              src_mac;
    logic [15:0]              frame_len;
    logic [31:0]              frame_count;
    logic [CFG_GAP_WIDTH-1:0] gap_cycles;
  } port_config_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } fg_state_t;

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    if (len < MIN_FRAME_LEN) return MIN_FRAME_LEN;
    if (len > MAX_FRAME_LEN) return MAX_FRAME_LEN;
    return len;
  endfunction

  // Byte at offset off: dst_mac, src_mac, ethertype, big-endian sequence,
  // then pad bytes equal to the offset modulo 256.
  function automatic logic [7:0] frame_byte(input logic [15:0] off,
                                            input logic [47:0] dst,
                                            input logic [47:0] src,
                                            input logic [31:0] seq);
    logic [15:0] o8;
    o8 = {off[12:0], 3'b000};
    if (off < 16'd6)  return 8'(dst >> (16'd40 - o8));
    if (off < 16'd12) return 8'(src >> (16'd88 - o8));
    if (off == 16'd12) return ETHERTYPE[15:8];
    if (off == 16'd13) return ETHERTYPE[7:0];
    if (off < 16'd18) return 8'(seq >> (16'd136 - o8));
    return off[7:0];
  endfunction

endpackage

// File: rtl/frame_beat_builder.sv
// Combinational beat content for the frame generator.
//   beat          : beat index within the frame (8 bytes per beat)
//   dst/src/len   : latched config, len already clamped
//   seq           : sequence number of the current frame
//   data/keep/last: AXI-Stream beat payload; byte i of a beat is data[8i+7:8i]
module frame_beat_builder
  import tester_common::*;
(
  input  logic [7:0]  beat,
  input  logic [47:0] dst,
  input  logic [47:0] src,
  input  logic [15:0] len,
  input  logic [31:0] seq,
  output logic [63:0] data,
  output logic [7:0]  keep,
  output logic        last
);
  localparam int NUM_LANES = 8;

  logic [15:0] last_beat;

  assign last_beat = ((len + 16'd7) >> 3) - 16'd1;
  assign last      = ({8'd0, beat} == last_beat);

  // Final beat keeps only the low len%8 lanes (all eight when len%8 == 0).
  always_comb begin
    keep = 8'hFF;
    if (last && len[2:0] != 3'd0) keep = 8'((9'd1 << len[2:0]) - 9'd1);
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign data[8*k +: 8] = frame_byte({5'd0, beat, 3'(k)}, dst, src, seq);
  end

endmodule

// File: rtl/frame_generator.sv
// Ethernet test-frame generator with an AXI-Stream master output.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, stop       : one-cycle pulses that begin / end a test
//   cfg               : test config, latched on start in IDLE
//   ready             : high in IDLE
//   tx_frames         : frames fully accepted since the last start (saturating)
//   m_axis_*          : 64-bit AXI-Stream master
module frame_generator
  import tester_common::*;
#(
  parameter int GAP_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  port_config_t cfg,
  output logic         ready,
  output logic [31:0]  tx_frames,
  output logic [63:0]  m_axis_tdata,
  output logic [7:0]   m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready
);

  fg_state_t            state, state_n;
  logic [47:0]          dst_q, src_q;
  logic [15:0]          len_q;
  logic [31:0]          count_q, seq_q, tx_inc;
  logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
  logic [7:0]           beat_q;
  logic                 stop_pend;
  logic                 load, adv, frame_done, hs, count_hit;
  logic [63:0]          b_data;
  logic [7:0]           b_keep;
  logic                 b_last;

  frame_beat_builder u_beat (
    .beat (beat_q),
    .dst  (dst_q),
    .src  (src_q),
    .len  (len_q),
    .seq  (seq_q),
    .data (b_data),
    .keep (b_keep),
    .last (b_last)
  );

  // Outputs come straight from registered beat state, so they cannot move
  // while a beat is stalled, and they read zero whenever tvalid is low.
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = m_axis_tvalid ? b_data : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? b_keep : '0;
  assign m_axis_tlast  = m_axis_tvalid & b_last;
  assign ready         = (state == IDLE);

  assign hs        = m_axis_tvalid & m_axis_tready;
  assign tx_inc    = (&tx_frames) ? tx_frames : tx_frames + 32'd1;
  assign count_hit = (count_q != '0) && (tx_inc == count_q);

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    adv        = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = SEND;
        load    = 1'b1;
      end
      SEND: if (hs) begin
        adv = 1'b1;
        if (b_last) begin
          frame_done = 1'b1;
          // A stop seen at any point in this frame (including this cycle)
          // ends the test once the frame is out.
          if (stop || stop_pend || count_hit) state_n = IDLE;
          else if (gap_q != '0)               state_n = GAP;
        end
      end
      GAP: begin
        if (stop)                              state_n = IDLE;
        else if (gap_cnt <= GAP_WIDTH'(1))     state_n = SEND;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dst_q     <= '0;
      src_q     <= '0;
      len_q     <= MIN_FRAME_LEN;
      count_q   <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      seq_q     <= '0;
      tx_frames <= '0;
      beat_q    <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        dst_q     <= cfg.dst_mac;
        src_q     <= cfg.src_mac;
        len_q     <= clamp_len(cfg.frame_len);
        count_q   <= cfg.frame_count;
        gap_q     <= GAP_WIDTH'(cfg.gap_cycles);
        seq_q     <= '0;
        tx_frames <= '0;
        beat_q    <= '0;
        stop_pend <= 1'b0;
      end
      if (adv) beat_q <= frame_done ? 8'd0 : beat_q + 8'd1;
      // The gap counter holds gap_cycles on entry to GAP and leaves at 1,
      // giving exactly gap_cycles idle cycles.
      if (frame_done) begin
        tx_frames <= tx_inc;
        seq_q     <= seq_q + 32'd1;
        gap_cnt   <= gap_q;
      end else if (state == GAP) begin
        gap_cnt   <= gap_cnt - GAP_WIDTH'(1);
      end
      if (state == SEND && stop) stop_pend <= 1'b1;
    end
  end

endmodule
